dpu_regmap_slave: RTL and testbench
===================================

DPU_REGMAP_SLAVE -- requirements
Module: dpu_regmap_slave

Interface
REQ-001 SHALL have parameter DPU_REG_ADDR_WTH, default 13: byte address width.
REQ-002 SHALL have parameter DPU_REG_DATA_WTH, default 32: data width.
REQ-003 SHALL have parameter NUM_CFG, default 16: number of RW config registers.
REQ-004 SHALL have parameter NUM_STAT, default 16: number of RO status registers.
REQ-005 clk  in  1  clock.
REQ-006 resetn  in  1  reset, synchronous, active-low.
REQ-007 riscv_regmap__waddr_i  in  DPU_REG_ADDR_WTH  write byte address.
REQ-008 riscv_regmap__we_i  in  1  write strobe, one write per high cycle.
REQ-009 riscv_regmap__wdata_i  in  DPU_REG_DATA_WTH  write data.
REQ-010 riscv_regmap__raddr_i  in  DPU_REG_ADDR_WTH  read byte address.
REQ-011 riscv_regmap__re_i  in  1  read strobe, one read per high cycle.
REQ-012 riscv_regmap__rdata_o  out  DPU_REG_DATA_WTH  read data.
REQ-013 riscv_regmap__rdata_act_o  out  1  read-data-valid pulse.
REQ-014 riscv_regmap__intr_o  out  8  interrupt lines to CPU, level.
REQ-015 dpu_evt_i  in  8  DPU event lines; rising edge raises interrupt.
REQ-016 stat_i  in  NUM_STAT*32  flattened status words, index 0 in LSBs.
REQ-017 cfg_o  out  NUM_CFG*32  flattened config words, index 0 in LSBs.

Function
REQ-018 Decode SHALL use addr[DPU_REG_ADDR_WTH-1:2]; addr[1:0] ignored.
REQ-019 Map: 0x000 ID RO 0x4850_5501; 0x004 INT_STATUS W1C; 0x008 INT_ENABLE RW (bits 7:0); 0x00C INT_RAW RO = dpu_evt_i; 0x010 SCRATCH RW; 0x014 ERR_CNT RO; 0x040+4k CFG[k] RW; 0x080+4k STAT[k] RO = stat_i word k.
REQ-020 Read: re_i high in cycle N SHALL give rdata_o valid and rdata_act_o=1 in cycle N+1 only; one pulse per strobe; back-to-back reads every cycle supported.
REQ-021 rdata_o SHALL hold last read value while rdata_act_o=0.
REQ-022 Write: we_i high in cycle N SHALL update target register visible from cycle N+1; writes to RO registers ignored.
REQ-023 Simultaneous we_i and re_i, same address: read SHALL return pre-write value.
REQ-024 Unmapped read SHALL return 0xDEAD_BEEF with normal rdata_act_o pulse; unmapped read or write SHALL increment ERR_CNT (16-bit, saturating at 0xFFFF, upper bits 0); simultaneous unmapped read and write count 2 (saturating).
REQ-025 INT_STATUS bit i SHALL set one cycle after dpu_evt_i[i] 0->1 (registered previous value); writing 1 clears, writing 0 no effect.
REQ-026 Same-cycle set and W1C clear on one bit: set SHALL win.
REQ-027 riscv_regmap__intr_o SHALL be registered INT_STATUS & INT_ENABLE, one cycle after either changes.
REQ-028 cfg_o SHALL be driven directly from CFG registers.

Reset
REQ-029 On resetn=0 at clk edge: rdata_o=0, rdata_act_o=0, intr_o=0, INT_STATUS=0, INT_ENABLE=0, SCRATCH=0, ERR_CNT=0, all CFG=0, event history=0.
REQ-030 Read strobed in the cycle before reset asserts SHALL produce no rdata_act_o pulse; strobes with resetn=0 ignored.
REQ-031 Event input already high at reset release SHALL NOT set INT_STATUS.

Structure
REQ-032 Shared package dpu_regmap_pkg SHALL hold register offsets, ID constant, 0xDEAD_BEEF default, ERR_CNT width.
REQ-033 Edge detect, W1C status, mask and intr register SHALL be sub-module dpu_regmap_intc.

Verification
REQ-034 Reset, read 0x000 -> rdata_act_o one cycle later, rdata_o=0x4850_5501; read 0x004 -> 0.
REQ-035 Write 0x040=0x1234_5678, read 0x040 next cycle -> 0x1234_5678; cfg_o[31:0]=0x1234_5678; same-cycle write 0x044=5 and read 0x044 -> returns 0.
REQ-036 INT_ENABLE=0x01, pulse dpu_evt_i[0] -> INT_STATUS=0x01, intr_o=0x01; write 0x004=0x01 -> intr_o=0x00; evt[1] edge with enable 0 -> status 0x02, intr_o 0.
REQ-037 W1C of bit 2 in same cycle as evt[2] rising edge -> INT_STATUS[2] stays 1.
REQ-038 Reads 0x1F00 and 0x0C0 back-to-back -> two pulses, 0xDEAD_BEEF each, ERR_CNT=2; preload near saturation -> holds 0xFFFF.
REQ-039 Read strobe then reset next cycle -> no rdata_act_o, all outputs 0.

Source files
------------

// File: rtl/dpu_regmap_pkg.sv
// Shared definitions for the DPU register map slave: register offsets,
// fixed read values, error counter width and the decoded-address type.
package dpu_regmap_pkg;

  localparam int unsigned OFS_ID         = 'h000;
  localparam int unsigned OFS_INT_STATUS = 'h004;
  localparam int unsigned OFS_INT_ENABLE = 'h008;
  localparam int unsigned OFS_INT_RAW    = 'h00C;
  localparam int unsigned OFS_SCRATCH    = 'h010;
  localparam int unsigned OFS_ERR_CNT    = 'h014;
  localparam int unsigned OFS_CFG_BASE   = 'h040;
  localparam int unsigned OFS_STAT_BASE  = 'h080;

  localparam logic [31:0] DPU_ID_VAL       = 32'h4850_5501;
  localparam logic [31:0] DPU_UNMAPPED_VAL = 32'hDEAD_BEEF;

  localparam int ERR_CNT_W = 16;
  localparam int INTR_W    = 8;

  // Register selected by a decoded address; SEL_NONE marks an unmapped access
  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_ID,
    SEL_INT_STATUS,
    SEL_INT_ENABLE,
    SEL_INT_RAW,
    SEL_SCRATCH,
    SEL_ERR_CNT,
    SEL_CFG,
    SEL_STAT
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e   sel;
    logic [7:0] idx;   // word index inside the CFG or STAT bank
  } reg_dec_t;

endpackage

// File: rtl/dpu_regmap_intc.sv
// Interrupt block: rising-edge detection on DPU events, write-1-to-clear
// status, enable mask and the registered interrupt lines to the CPU.
module dpu_regmap_intc
  import dpu_regmap_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic [INTR_W-1:0] evt,
  input  logic              clr_we,
  input  logic [INTR_W-1:0] clr_mask,
  input  logic              en_we,
  input  logic [INTR_W-1:0] en_data,
  output logic [INTR_W-1:0] status,
  output logic [INTR_W-1:0] enable,
  output logic [INTR_W-1:0] intr
);

  logic [INTR_W-1:0] evt_prev_q;
  logic              armed_q;
  logic [INTR_W-1:0] status_q;
  logic [INTR_W-1:0] enable_q;
  logic [INTR_W-1:0] intr_q;
  logic [INTR_W-1:0] rise;
  logic [INTR_W-1:0] clr;

  // The first cycle after reset only records the event levels, so a line
  // that is already high when reset releases is not mistaken for an edge.
  assign rise = evt & ~evt_prev_q & {INTR_W{armed_q}};
  assign clr  = clr_we ? clr_mask : '0;

  // Edge history, sticky status (set beats clear), enable mask, output lines
  always_ff @(posedge clk) begin
    if (!resetn) begin
      evt_prev_q <= '0;
      armed_q    <= 1'b0;
      status_q   <= '0;
      enable_q   <= '0;
      intr_q     <= '0;
    end else begin
      evt_prev_q <= evt;
      armed_q    <= 1'b1;
      status_q   <= (status_q & ~clr) | rise;
      if (en_we) enable_q <= en_data;
      intr_q     <= status_q & enable_q;
    end
  end

  assign status = status_q;
  assign enable = enable_q;
  assign intr   = intr_q;

endmodule

// File: rtl/dpu_regmap_slave.sv
// CPU-facing register map of the DPU: ID, interrupt registers, scratch,
// access-error counter, RW config bank and RO status bank. Reads return
// data one cycle after the strobe; writes take effect on the next cycle.
module dpu_regmap_slave
  import dpu_regmap_pkg::*;
#(
  parameter int DPU_REG_ADDR_WTH = 13,
  parameter int DPU_REG_DATA_WTH = 32,
  parameter int NUM_CFG          = 16,
  parameter int NUM_STAT         = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [DPU_REG_ADDR_WTH-1:0] riscv_regmap__waddr_i,
  input  logic                        riscv_regmap__we_i,
  input  logic [DPU_REG_DATA_WTH-1:0] riscv_regmap__wdata_i,
  input  logic [DPU_REG_ADDR_WTH-1:0] riscv_regmap__raddr_i,
  input  logic                        riscv_regmap__re_i,
  output logic [DPU_REG_DATA_WTH-1:0] riscv_regmap__rdata_o,
  output logic                        riscv_regmap__rdata_act_o,
  output logic [7:0]                  riscv_regmap__intr_o,
  input  logic [7:0]                  dpu_evt_i,
  input  logic [NUM_STAT*32-1:0]      stat_i,
  output logic [NUM_CFG*32-1:0]       cfg_o
);

  localparam int DW = DPU_REG_DATA_WTH;

  logic [DW-1:0]        scratch_q;
  logic [DW-1:0]        cfg_q [NUM_CFG];
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [DW-1:0]        rd_data_p1;
  logic                 vld_p1;
  logic [DW-1:0]        rd_mux;
  reg_dec_t             rdec;
  reg_dec_t             wdec;
  logic                 rd_err;
  logic                 wr_err;
  logic [1:0]           err_inc;
  logic [INTR_W-1:0]    int_status;
  logic [INTR_W-1:0]    int_enable;

  // Word-granular decode; the two byte-lane bits never take part
  function automatic reg_dec_t decode(input logic [DPU_REG_ADDR_WTH-1:0] addr);
    int unsigned w;
    reg_dec_t    d;
    w     = 32'(addr[DPU_REG_ADDR_WTH-1:2]);
    d.sel = SEL_NONE;
    d.idx = '0;
    if (w == (OFS_ID >> 2))              d.sel = SEL_ID;
    else if (w == (OFS_INT_STATUS >> 2)) d.sel = SEL_INT_STATUS;
    else if (w == (OFS_INT_ENABLE >> 2)) d.sel = SEL_INT_ENABLE;
    else if (w == (OFS_INT_RAW >> 2))    d.sel = SEL_INT_RAW;
    else if (w == (OFS_SCRATCH >> 2))    d.sel = SEL_SCRATCH;
    else if (w == (OFS_ERR_CNT >> 2))    d.sel = SEL_ERR_CNT;
    else if (w >= (OFS_CFG_BASE >> 2) &&
             w <  (OFS_CFG_BASE >> 2) + int'(unsigned'(NUM_CFG))) begin
      d.sel = SEL_CFG;
      d.idx = 8'(w - (OFS_CFG_BASE >> 2));
    end else if (w >= (OFS_STAT_BASE >> 2) &&
                 w <  (OFS_STAT_BASE >> 2) + int'(unsigned'(NUM_STAT))) begin
      d.sel = SEL_STAT;
      d.idx = 8'(w - (OFS_STAT_BASE >> 2));
    end
    return d;
  endfunction

  // Error counter add that sticks at all-ones instead of wrapping
  function automatic logic [ERR_CNT_W-1:0] err_sat_add(input logic [ERR_CNT_W-1:0] cnt,
                                                       input logic [1:0]           inc);
    logic [ERR_CNT_W:0] sum;
    sum = {1'b0, cnt} + (ERR_CNT_W + 1)'(inc);
    return sum[ERR_CNT_W] ? '1 : sum[ERR_CNT_W-1:0];
  endfunction

  assign rdec    = decode(riscv_regmap__raddr_i);
  assign wdec    = decode(riscv_regmap__waddr_i);
  assign rd_err  = riscv_regmap__re_i && (rdec.sel == SEL_NONE);
  assign wr_err  = riscv_regmap__we_i && (wdec.sel == SEL_NONE);
  assign err_inc = {1'b0, rd_err} + {1'b0, wr_err};

  // Read multiplexer over the current (pre-write) register contents
  always_comb begin
    rd_mux = DW'(DPU_UNMAPPED_VAL);
    case (rdec.sel)
      SEL_ID:         rd_mux = DW'(DPU_ID_VAL);
      SEL_INT_STATUS: rd_mux = DW'(int_status);
      SEL_INT_ENABLE: rd_mux = DW'(int_enable);
      SEL_INT_RAW:    rd_mux = DW'(dpu_evt_i);
      SEL_SCRATCH:    rd_mux = scratch_q;
      SEL_ERR_CNT:    rd_mux = DW'(err_cnt_q);
      SEL_CFG: begin
        for (int k = 0; k < NUM_CFG; k++)
          if (int'(rdec.idx) == k) rd_mux = cfg_q[k];
      end
      SEL_STAT: begin
        for (int k = 0; k < NUM_STAT; k++)
          if (int'(rdec.idx) == k) rd_mux = DW'(stat_i[k*32 +: 32]);
      end
      default: ;
    endcase
  end

  // Read response stage: one valid pulse per strobe, data held between reads
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_p1     <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      vld_p1 <= riscv_regmap__re_i;
      if (riscv_regmap__re_i) rd_data_p1 <= rd_mux;
    end
  end

  // Writable registers and the access-error counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      scratch_q <= '0;
      err_cnt_q <= '0;
      for (int k = 0; k < NUM_CFG; k++) cfg_q[k] <= '0;
    end else begin
      if (riscv_regmap__we_i && wdec.sel == SEL_SCRATCH) scratch_q <= riscv_regmap__wdata_i;
      for (int k = 0; k < NUM_CFG; k++)
        if (riscv_regmap__we_i && wdec.sel == SEL_CFG && int'(wdec.idx) == k)
          cfg_q[k] <= riscv_regmap__wdata_i;
      err_cnt_q <= err_sat_add(err_cnt_q, err_inc);
    end
  end

  dpu_regmap_intc u_intc (
    .clk      (clk),
    .resetn   (resetn),
    .evt      (dpu_evt_i),
    .clr_we   (riscv_regmap__we_i && wdec.sel == SEL_INT_STATUS),
    .clr_mask (riscv_regmap__wdata_i[INTR_W-1:0]),
    .en_we    (riscv_regmap__we_i && wdec.sel == SEL_INT_ENABLE),
    .en_data  (riscv_regmap__wdata_i[INTR_W-1:0]),
    .status   (int_status),
    .enable   (int_enable),
    .intr     (riscv_regmap__intr_o)
  );

  for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg_out
    assign cfg_o[k*32 +: 32] = 32'(cfg_q[k]);
  end

  assign riscv_regmap__rdata_o     = rd_data_p1;
  assign riscv_regmap__rdata_act_o = vld_p1;

endmodule

// File: tb/tb_dpu_regmap_slave.sv
// Bench for dpu_regmap_slave: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural register-map model.
module tb_dpu_regmap_slave;

  localparam int NCFG  = 16;
  localparam int NSTAT = 16;

  logic              clk = 1'b0;
  logic              resetn;
  logic [12:0]       waddr, raddr;
  logic              we, re;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              rdata_act;
  logic [7:0]        intr;
  logic [7:0]        evt;
  logic [NSTAT*32-1:0] stat;
  logic [NCFG*32-1:0]  cfg;

  int checks   = 0;
  int failures = 0;

  dpu_regmap_slave dut (
    .clk                       (clk),
    .resetn                    (resetn),
    .riscv_regmap__waddr_i     (waddr),
    .riscv_regmap__we_i        (we),
    .riscv_regmap__wdata_i     (wdata),
    .riscv_regmap__raddr_i     (raddr),
    .riscv_regmap__re_i        (re),
    .riscv_regmap__rdata_o     (rdata),
    .riscv_regmap__rdata_act_o (rdata_act),
    .riscv_regmap__intr_o      (intr),
    .dpu_evt_i                 (evt),
    .stat_i                    (stat),
    .cfg_o                     (cfg)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_cfg [NCFG];
  logic [31:0] m_scratch, m_rdata;
  logic [7:0]  m_en, m_status, m_intr, m_prev;
  logic        m_act, m_armed, m_init = 1'b0;
  int          m_err;

  function automatic bit m_mapped(input logic [12:0] a);
    int w;
    w = int'(a[12:2]);
    return (w <= 5) || (w >= 16 && w < 16 + NCFG) || (w >= 32 && w < 32 + NSTAT);
  endfunction

  function automatic logic [31:0] m_read(input logic [12:0] a);
    int w;
    w = int'(a[12:2]);
    if (w == 0) return 32'h4850_5501;
    if (w == 1) return {24'h0, m_status};
    if (w == 2) return {24'h0, m_en};
    if (w == 3) return {24'h0, evt};
    if (w == 4) return m_scratch;
    if (w == 5) return 32'(m_err);
    if (w >= 16 && w < 16 + NCFG) return m_cfg[w-16];
    if (w >= 32 && w < 32 + NSTAT) return stat[(w-32)*32 +: 32];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic model_step();
    logic [7:0]  rise, clr;
    logic [31:0] rv;
    int w;
    m_init = 1'b1;
    if (!resetn) begin
      for (int k = 0; k < NCFG; k++) m_cfg[k] = 0;
      m_scratch = 0; m_rdata = 0; m_en = 0; m_status = 0; m_intr = 0;
      m_prev = 0; m_act = 0; m_armed = 0; m_err = 0;
      return;
    end
    rv = m_read(raddr);
    m_act = re;
    if (re) m_rdata = rv;
    if (re && !m_mapped(raddr)) m_err++;
    if (we && !m_mapped(waddr)) m_err++;
    if (m_err > 32'hFFFF) m_err = 32'hFFFF;
    rise = m_armed ? (evt & ~m_prev) : 8'h00;
    m_intr = m_status & m_en;
    w = int'(waddr[12:2]);
    clr = (we && w == 1) ? wdata[7:0] : 8'h00;
    m_status = (m_status & ~clr) | rise;
    if (we && w == 2) m_en = wdata[7:0];
    if (we && w == 4) m_scratch = wdata;
    if (we && w >= 16 && w < 16 + NCFG) m_cfg[w-16] = wdata;
    m_prev = evt;
    m_armed = 1'b1;
  endtask

  // ---------------- literal expectations from the driver ----------------
  typedef struct {
    int          sig;    // 0 rdata, 1 act, 2 intr, 3 cfg word 0, 4 any cfg bit set
    logic [31:0] val;
    string       name;
  } lit_t;
  lit_t lit_q[$];

  task automatic expect_lit(input int sig, input logic [31:0] val, input string name);
    lit_t l;
    l.sig = sig; l.val = val; l.name = name;
    lit_q.push_back(l);
  endtask

  task automatic chk(input string n, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  // Model update on each edge, then compare DUT outputs just after it
  always @(posedge clk) begin
    logic [NCFG*32-1:0] ecfg;
    lit_t l;
    model_step();
    #1;
    for (int k = 0; k < NCFG; k++) ecfg[k*32 +: 32] = m_cfg[k];
    chk("model_rdata", 512'(rdata), 512'(m_rdata));
    chk("model_act", 512'(rdata_act), 512'(m_act));
    chk("model_intr", 512'(intr), 512'(m_intr));
    chk("model_cfg", 512'(cfg), 512'(ecfg));
    while (lit_q.size() > 0) begin
      l = lit_q.pop_front();
      case (l.sig)
        0: chk(l.name, 512'(rdata), 512'(l.val));
        1: chk(l.name, 512'(rdata_act), 512'(l.val[0]));
        2: chk(l.name, 512'(intr), 512'(l.val[7:0]));
        3: chk(l.name, 512'(cfg[31:0]), 512'(l.val));
        default: chk(l.name, 512'(|cfg), 512'(l.val[0]));
      endcase
    end
  end

  // ---------------- driver ----------------
  task automatic do_read(input logic [12:0] a, input logic [31:0] exp, input string n);
    re = 1'b1; raddr = a;
    expect_lit(0, exp, n);
    expect_lit(1, 32'd1, {n, "_act"});
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic do_write(input logic [12:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  function automatic logic [12:0] pick_addr();
    logic [12:0] a;
    case ($urandom_range(0, 9))
      0, 1:    a = 13'($urandom_range(0, 5) * 4);
      2, 3, 4: a = 13'(32'h040 + $urandom_range(0, NCFG - 1) * 4);
      5, 6:    a = 13'(32'h080 + $urandom_range(0, NSTAT - 1) * 4);
      7:       a = 13'(32'h0C0 + $urandom_range(0, 63) * 4);
      8:       a = 13'($urandom_range(6, 15) * 4);
      default: a = 13'($urandom);
    endcase
    if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom);
    return a;
  endfunction

  initial begin
    resetn = 1'b0; we = 0; re = 0; waddr = 0; raddr = 0; wdata = 0; evt = 0;
    for (int k = 0; k < NSTAT; k++) stat[k*32 +: 32] = 32'h5000_0000 + 32'(k);
    expect_lit(0, 0, "reset_rdata");
    expect_lit(1, 0, "reset_act");
    expect_lit(2, 0, "reset_intr");
    expect_lit(4, 0, "reset_cfg");
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    do_read(13'h000, 32'h4850_5501, "id");
    do_read(13'h004, 32'h0, "int_status_reset");
    do_read(13'h014, 32'h0, "err_cnt_reset");
    do_read(13'h08C, 32'h5000_0003, "stat3");

    do_write(13'h040, 32'h1234_5678);
    expect_lit(3, 32'h1234_5678, "cfg0_out");
    do_read(13'h040, 32'h1234_5678, "cfg0_read");
    we = 1'b1; waddr = 13'h044; wdata = 32'd5;
    do_read(13'h044, 32'h0, "same_cycle_rw");
    we = 1'b0;
    do_read(13'h047, 32'd5, "cfg1_after_write");

    do_write(13'h008, 32'h01);
    evt = 8'h01;
    @(negedge clk);
    evt = 8'h00;
    expect_lit(2, 32'h01, "intr_evt0");
    @(negedge clk);
    do_read(13'h004, 32'h01, "status_evt0");
    do_write(13'h004, 32'h01);
    expect_lit(2, 32'h00, "intr_cleared");
    @(negedge clk);
    evt = 8'h02;
    @(negedge clk);
    evt = 8'h00;
    @(negedge clk);
    expect_lit(2, 32'h00, "intr_masked");
    do_read(13'h004, 32'h02, "status_evt1");

    do_write(13'h004, 32'hFF);
    evt = 8'h04; we = 1'b1; waddr = 13'h004; wdata = 32'h04;
    @(negedge clk);
    evt = 8'h00; we = 1'b0;
    do_read(13'h004, 32'h04, "set_beats_clear");

    re = 1'b1; raddr = 13'h1F00;
    expect_lit(0, 32'hDEAD_BEEF, "unmapped_a");
    expect_lit(1, 1, "unmapped_a_act");
    @(negedge clk);
    raddr = 13'h0C0;
    expect_lit(0, 32'hDEAD_BEEF, "unmapped_b");
    expect_lit(1, 1, "unmapped_b_act");
    @(negedge clk);
    re = 1'b0;
    do_read(13'h014, 32'd2, "err_cnt_two");

    for (int c = 0; c < 2500; c++) begin
      re = 1'($urandom_range(0, 1));
      raddr = pick_addr();
      we = ($urandom_range(0, 2) == 0);
      waddr = pick_addr();
      wdata = $urandom;
      if ($urandom_range(0, 3) == 0) evt = evt ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0)
        for (int k = 0; k < NSTAT; k++) stat[k*32 +: 32] = $urandom;
      @(negedge clk);
    end
    re = 0; we = 0; evt = 0;
    @(negedge clk);

    re = 1'b1; we = 1'b1; raddr = 13'h0C0; waddr = 13'h1F00; wdata = 0;
    repeat (33000) @(negedge clk);
    re = 1'b0; we = 1'b0;
    do_read(13'h014, 32'h0000_FFFF, "err_cnt_saturated");

    re = 1'b1; raddr = 13'h000; resetn = 1'b0; evt = 8'h10;
    expect_lit(1, 0, "strobe_into_reset_act");
    expect_lit(0, 0, "strobe_into_reset_rdata");
    expect_lit(2, 0, "strobe_into_reset_intr");
    expect_lit(4, 0, "strobe_into_reset_cfg");
    @(negedge clk);
    re = 1'b0;
    expect_lit(1, 0, "reset_no_pulse");
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    do_read(13'h004, 32'h0, "evt_high_at_release");
    evt = 8'h00;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
